// File: rtl/hex_scan_pkg.sv
// -----------------------------------------------------------------------------
// hex_scan_pkg
// Shared types, constants and helpers for the hex_scan_ctrl display scanner.
//   SEG_BLANK      : segment pattern with every segment and the DP dark
//   nibble_t       : one hexadecimal digit
//   lzb_blank_vec  : per-digit leading-zero blanking vector
// -----------------------------------------------------------------------------
package hex_scan_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         MAX_DIGITS = 8;
  localparam int         MAX_IDX_W  = 3;
  localparam int         EXT_W      = 4 * MAX_DIGITS;

  typedef logic [3:0] nibble_t;

  // Digit k (k>0) is blanked when lzb is set and every nibble from the top
  // digit down to k is zero. Digit 0 always stays lit so a zero value still
  // shows "0". Digits at or above num_digits are never blanked.
  function automatic logic [MAX_DIGITS-1:0] lzb_blank_vec(
    input logic [EXT_W-1:0] value,
    input int               num_digits,
    input logic             lzb
  );
    logic [MAX_DIGITS-1:0] blank;
    logic                  upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < num_digits) begin
        upper_zero = upper_zero && (value[4*k +: 4] == 4'h0);
        blank[k]   = lzb && upper_zero;
      end else begin
        blank[k]   = 1'b0;
      end
    end
    return blank;
  endfunction

endpackage

// File: rtl/decord_7seg.sv
// -----------------------------------------------------------------------------
// decord_7seg
// Hex-to-seven-segment decoder, active-low segments, bit7 = DP (always off).
//   DIN [3:0] : nibble to decode
//   EN        : 0 forces every segment dark
//   HEX [7:0] : active-low pattern {dp, g, f, e, d, c, b, a}
// -----------------------------------------------------------------------------
module decord_7seg
  import hex_scan_pkg::*;
(
  input  logic [3:0] DIN,
  input  logic       EN,
  output logic [7:0] HEX
);

  // Combinational nibble-to-segment lookup
  always_comb begin
    HEX = SEG_BLANK;
    if (EN) begin
      case (DIN)
        4'h0:    HEX = 8'hC0;
        4'h1:    HEX = 8'hF9;
        4'h2:    HEX = 8'hA4;
        4'h3:    HEX = 8'hB0;
        4'h4:    HEX = 8'h99;
        4'h5:    HEX = 8'h92;
        4'h6:    HEX = 8'h82;
        4'h7:    HEX = 8'hF8;
        4'h8:    HEX = 8'h80;
        4'h9:    HEX = 8'h90;
        4'hA:    HEX = 8'h88;
        4'hB:    HEX = 8'h83;
        4'hC:    HEX = 8'hC6;
        4'hD:    HEX = 8'hA1;
        4'hE:    HEX = 8'h86;
        4'hF:    HEX = 8'h8E;
        default: HEX = SEG_BLANK;
      endcase
    end else begin
      HEX = SEG_BLANK;
    end
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-seg digits
// sharing one decoder. Loaded values wait in a pending register and are
// committed only at a frame boundary, so a frame never shows a torn value.
// Optional feature macro: HEX_SCAN_BLINK_EN (adds BLINK port, BLINK_FRAMES).
// Ports:
//   CLK, RST_N  : clock, synchronous active-low reset
//   DIN         : value to load, nibble k drives digit k (k=0 = LSD)
//   DP_IN       : per-digit decimal point, 1 = lit, captured with DIN
//   LZB         : leading-zero blanking enable, sampled live
//   LOAD_VALID  : load request; LOAD_READY : load can be accepted
//   DISP_EN     : 0 turns all segments and digit selects off
//   HEX         : active-low segments, bit7 = DP
//   DIG_N       : active-low one-hot digit select
//   FRAME_DONE  : one-cycle pulse per completed scan frame
// -----------------------------------------------------------------------------
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000
`ifdef HEX_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] DIN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    LZB,
  input  logic                    LOAD_VALID,
  output logic                    LOAD_READY,
  input  logic                    DISP_EN,
`ifdef HEX_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   BLINK,
`endif
  output logic [7:0]              HEX,
  output logic [NUM_DIGITS-1:0]   DIG_N,
  output logic                    FRAME_DONE
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [DW-1:0]         r_shown;
  logic [NUM_DIGITS-1:0] r_shown_dp;
  logic [DW-1:0]         r_pend_din;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend;
  logic                  r_ready;
  logic                  r_frame_done;
  logic [7:0]            r_hex;
  logic [NUM_DIGITS-1:0] r_dig_n;

  logic                  w_term;
  logic                  w_frame_end;
  logic                  w_xfer;
  logic [PRE_W-1:0]      w_presc_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DW-1:0]         w_shown_nxt;
  logic [NUM_DIGITS-1:0] w_shown_dp_nxt;
  logic                  w_pend_nxt;
  logic [MAX_DIGITS-1:0] w_blank_all;
  logic                  w_blank_sel;
  logic                  w_dp_on;
  nibble_t               w_nib;
  logic [7:0]            w_dec_hex;
  logic [7:0]            w_hex_nxt;
  logic [NUM_DIGITS-1:0] w_dig_n_nxt;
  logic                  w_blink_mask;

  assign w_term      = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign w_frame_end = w_term && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_xfer      = LOAD_VALID && r_ready;

  // Next prescaler/index, commit of pending data and pending-flag update
  always_comb begin
    w_presc_nxt    = r_presc;
    w_idx_nxt      = r_idx;
    w_shown_nxt    = r_shown;
    w_shown_dp_nxt = r_shown_dp;
    w_pend_nxt     = r_pend;
    if (w_term) begin
      w_presc_nxt = '0;
      if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
        w_idx_nxt = '0;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end else begin
      w_presc_nxt = r_presc + PRE_W'(1);
      w_idx_nxt   = r_idx;
    end
    if (w_frame_end && r_pend) begin
      w_shown_nxt    = r_pend_din;
      w_shown_dp_nxt = r_pend_dp;
      w_pend_nxt     = 1'b0;
    end else begin
      w_shown_nxt    = r_shown;
      w_shown_dp_nxt = r_shown_dp;
      w_pend_nxt     = r_pend;
    end
    // A transfer needs ready, which implies nothing is pending to commit.
    if (w_xfer) begin
      w_pend_nxt = 1'b1;
    end else begin
      w_pend_nxt = w_pend_nxt;
    end
  end

  // Outputs are built from next-state values so the digit select, the new
  // value on digit 0 and FRAME_DONE all appear on the same edge.
  always_comb begin
    w_blank_all = lzb_blank_vec(EXT_W'(w_shown_nxt), NUM_DIGITS, LZB);
    w_blank_sel = w_blank_all[MAX_IDX_W'(w_idx_nxt)];
    w_nib       = w_shown_nxt[{w_idx_nxt, 2'b00} +: 4];
    // A blanked digit keeps its DP dark as well.
    w_dp_on     = w_shown_dp_nxt[w_idx_nxt] && !w_blank_sel;
  end

  decord_7seg u_dec (
    .DIN (w_nib),
    .EN  (~w_blank_sel),
    .HEX (w_dec_hex)
  );

  // Final segment/digit-select pattern including display enable and blink
  always_comb begin
    w_hex_nxt   = SEG_BLANK;
    w_dig_n_nxt = '1;
    if (!DISP_EN) begin
      w_hex_nxt   = SEG_BLANK;
      w_dig_n_nxt = '1;
    end else if (w_blink_mask) begin
      w_hex_nxt   = SEG_BLANK;
      w_dig_n_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
    end else begin
      w_hex_nxt   = w_dec_hex & {~w_dp_on, 7'h7F};
      w_dig_n_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
    end
  end

`ifdef HEX_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0] r_blink_cnt;
  logic            r_blink_off;

  assign w_blink_mask = r_blink_off && BLINK[w_idx_nxt];

  // Frame counter toggling the blink phase every BLINK_FRAMES frames
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + BF_W'(1);
      end
    end
  end
`else
  assign w_blink_mask = 1'b0;
`endif

  // Scan counters, value buffers, handshake and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shown      <= '0;
      r_shown_dp   <= '0;
      r_pend_din   <= '0;
      r_pend_dp    <= '0;
      r_pend       <= 1'b0;
      r_ready      <= 1'b1;
      r_frame_done <= 1'b0;
      r_hex        <= SEG_BLANK;
      r_dig_n      <= '1;
    end else begin
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_shown      <= w_shown_nxt;
      r_shown_dp   <= w_shown_dp_nxt;
      r_pend       <= w_pend_nxt;
      r_ready      <= ~w_pend_nxt;
      r_frame_done <= w_frame_end;
      r_hex        <= w_hex_nxt;
      r_dig_n      <= w_dig_n_nxt;
      if (w_xfer) begin
        r_pend_din <= DIN;
        r_pend_dp  <= DP_IN;
      end
    end
  end

  assign LOAD_READY = r_ready;
  assign FRAME_DONE = r_frame_done;
  assign HEX        = r_hex;
  assign DIG_N      = r_dig_n;

endmodule
